// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: edge-latched, masked, fixed-priority non-nesting interrupt requester
//   clk, reset (sync, active-low) | irq_in raw lines | mask_we/mask_wdata enable mask
//   irq_ack / irq_done handshake pulses | interrupt, vec_addr, active_id, in_service, pending
module irq_priority_ctrl #(
  parameter int N_IRQ = 4,
  parameter int ID_W = 2,
  parameter logic [7:0] VEC_BASE = 8'hF0,
  parameter logic [7:0] VEC_STRIDE = 8'h02
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             irq_done,
  output logic             interrupt,
  output logic [7:0]       vec_addr,
  output logic [ID_W-1:0]  active_id,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_n;
  logic [N_IRQ-1:0] irq_prev, mask, req, clr;
  logic [ID_W-1:0] sel_id;
  logic [7:0] sel_vec;
  assign req = pending & mask;
  assign interrupt = state == REQ;
  assign in_service = state == SERVICE;
  // ack clears only the serviced bit; a same-cycle new edge is OR-ed back in, so set wins
  assign clr = (state == REQ && irq_ack) ? N_IRQ'(1) << active_id : '0;
  assign sel_vec = VEC_BASE + 8'(sel_id) * VEC_STRIDE;
  always_comb begin
    sel_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (req[i]) sel_id = ID_W'(i);
  end
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = |req ? REQ : IDLE;
      REQ:     state_n = irq_ack ? SERVICE : REQ;
      SERVICE: state_n = irq_done ? IDLE : SERVICE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      irq_prev <= '0;
      mask <= '0;
      pending <= '0;
      active_id <= '0;
      vec_addr <= '0;
    end else begin
      state <= state_n;
      irq_prev <= irq_in;
      pending <= (pending & ~clr) | (irq_in & ~irq_prev);
      if (mask_we) mask <= mask_wdata;
      if (state == IDLE && |req) begin
        active_id <= sel_id;
        vec_addr <= sel_vec;
      end
    end
  end
endmodule
